// File: rtl/modsqr_vdf_sequencer_if.sv
// rtl/modsqr_vdf_sequencer_if.sv - host job request / result response channel bundle

interface modsqr_vdf_sequencer_if #(
    parameter int MOD_LEN = 1024,
    parameter int CNT_W   = 64
);
    logic               req_valid;
    logic               req_ready;
    logic [MOD_LEN-1:0] req_x;
    logic [CNT_W-1:0]   req_t;

    logic               resp_valid;
    logic               resp_ready;
    logic [MOD_LEN-1:0] resp_y;
    logic [CNT_W-1:0]   resp_iters;
    logic               resp_err;

    // Host side: issues jobs and consumes results.
    modport master (
        output req_valid, req_x, req_t, resp_ready,
        input  req_ready, resp_valid, resp_y, resp_iters, resp_err
    );

    // Sequencer side: accepts jobs and produces results.
    modport slave (
        input  req_valid, req_x, req_t, resp_ready,
        output req_ready, resp_valid, resp_y, resp_iters, resp_err
    );
endinterface

// File: rtl/modsqr_vdf_sequencer.sv
// rtl/modsqr_vdf_sequencer.sv - job sequencer driving the pipelined modular squarer

module modsqr_vdf_sequencer #(
    parameter int MOD_LEN         = 1024,
    parameter int CNT_W           = 64,
    parameter int SQ_RESET_CYCLES = 8,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    modsqr_vdf_sequencer_if.slave host,
    output logic                 busy_o,
    output logic                 sq_reset_o,
    output logic                 sq_start_o,
    output logic [MOD_LEN-1:0]   sq_in_o,
    input  logic [MOD_LEN-1:0]   sq_out_i,
    input  logic                 sq_valid_i
);

    // Counters run 0..N-1; the terminal value is N-1.
    localparam int RST_W = (SQ_RESET_CYCLES > 1) ? $clog2(SQ_RESET_CYCLES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SQRST,
        ST_LAUNCH,
        ST_RUN,
        ST_STOP,
        ST_RESP
    } state_t;

    state_t             state_q, state_d;

    logic               armed_q;
    logic [MOD_LEN-1:0] x_q;
    logic [CNT_W-1:0]   t_q;
    logic [CNT_W-1:0]   iter_cnt_q;
    logic [TMR_W-1:0]   timer_q;
    logic [RST_W-1:0]   rst_cnt_q;
    logic [MOD_LEN-1:0] last_y_q;
    logic [MOD_LEN-1:0] sq_in_q;
    logic [MOD_LEN-1:0] resp_y_q;
    logic [CNT_W-1:0]   resp_iters_q;
    logic               resp_err_q;

    logic               accept;
    logic               t_zero;
    logic               rst_done;
    logic [CNT_W-1:0]   iter_inc;
    logic               run_done;
    logic               run_timeout;
    logic               resp_take;

    assign accept      = host.req_valid && host.req_ready;
    assign t_zero      = (host.req_t == '0);
    assign rst_done    = (rst_cnt_q == RST_W'(SQ_RESET_CYCLES - 1));
    assign iter_inc    = iter_cnt_q + CNT_W'(1);
    // A valid on the last allowed timer cycle still counts: sq_valid wins over the timeout.
    assign run_done    = (state_q == ST_RUN) && sq_valid_i && (iter_inc == t_q);
    assign run_timeout = (state_q == ST_RUN) && !sq_valid_i
                         && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    assign resp_take   = host.resp_valid && host.resp_ready;

    assign host.resp_y     = resp_y_q;
    assign host.resp_iters = resp_iters_q;
    assign host.resp_err   = resp_err_q;
    assign sq_in_o         = sq_in_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = t_zero ? ST_RESP : ST_SQRST;
                end
            end
            ST_SQRST: begin
                if (rst_done) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (run_done || run_timeout) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_take) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and squarer control outputs; reset forces them to their idle values at once.
    always_comb begin
        host.req_ready  = 1'b0;
        host.resp_valid = 1'b0;
        busy_o          = 1'b1;
        sq_reset_o      = 1'b1;
        sq_start_o      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_o         = 1'b0;
                host.req_ready = armed_q;
            end
            ST_LAUNCH: begin
                sq_reset_o = 1'b0;
                sq_start_o = 1'b1;
            end
            ST_RUN: begin
                sq_reset_o = 1'b0;
            end
            ST_RESP: begin
                host.resp_valid = 1'b1;
            end
            default: begin
                sq_reset_o = 1'b1;
            end
        endcase
        if (reset) begin
            host.req_ready  = 1'b0;
            host.resp_valid = 1'b0;
            busy_o          = 1'b0;
            sq_reset_o      = 1'b1;
            sq_start_o      = 1'b0;
        end
    end

    // Job operands, iteration/timeout counters and the held response.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed_q      <= 1'b0;
            x_q          <= '0;
            t_q          <= '0;
            iter_cnt_q   <= '0;
            timer_q      <= '0;
            rst_cnt_q    <= '0;
            last_y_q     <= '0;
            sq_in_q      <= '0;
            resp_y_q     <= '0;
            resp_iters_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        x_q        <= host.req_x;
                        t_q        <= host.req_t;
                        iter_cnt_q <= '0;
                        timer_q    <= '0;
                        rst_cnt_q  <= '0;
                        last_y_q   <= host.req_x;
                        if (t_zero) begin
                            resp_y_q     <= host.req_x;
                            resp_iters_q <= '0;
                            resp_err_q   <= 1'b0;
                        end
                    end
                end
                ST_SQRST: begin
                    rst_cnt_q <= rst_cnt_q + RST_W'(1);
                    if (rst_done) begin
                        sq_in_q <= x_q;
                    end
                end
                ST_RUN: begin
                    if (sq_valid_i) begin
                        iter_cnt_q <= iter_inc;
                        timer_q    <= '0;
                        last_y_q   <= sq_out_i;
                        if (run_done) begin
                            resp_y_q     <= sq_out_i;
                            resp_iters_q <= t_q;
                            resp_err_q   <= 1'b0;
                        end
                    end else if (run_timeout) begin
                        resp_y_q     <= last_y_q;
                        resp_iters_q <= iter_cnt_q;
                        resp_err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modsqr_vdf_sequencer.sv
// tb/tb_modsqr_vdf_sequencer.sv - scoreboard bench for modsqr_vdf_sequencer with a mod-1009 squarer model

module tb_modsqr_vdf_sequencer;

    localparam int MOD_LEN = 32;
    localparam int CNT_W   = 16;
    localparam int SQRST   = 8;
    localparam int TMO     = 64;
    localparam int LAT     = 20;
    localparam int PRIME   = 1009;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    modsqr_vdf_sequencer_if #(.MOD_LEN(MOD_LEN), .CNT_W(CNT_W)) host_if();

    logic               busy;
    logic               sq_reset;
    logic               sq_start;
    logic [MOD_LEN-1:0] sq_in;
    logic [MOD_LEN-1:0] sq_out   = '0;
    logic               sq_valid = 1'b0;

    modsqr_vdf_sequencer #(
        .MOD_LEN(MOD_LEN), .CNT_W(CNT_W),
        .SQ_RESET_CYCLES(SQRST), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .host(host_if.slave),
        .busy_o(busy), .sq_reset_o(sq_reset), .sq_start_o(sq_start),
        .sq_in_o(sq_in), .sq_out_i(sq_out), .sq_valid_i(sq_valid)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] y;
        logic [63:0] iters;
        logic [63:0] err;
    } exp_t;
    exp_t sb_q[$];

    function automatic logic [MOD_LEN-1:0] sq_mod(input logic [MOD_LEN-1:0] v);
        logic [63:0] w;
        w = 64'(v) * 64'(v);
        return MOD_LEN'(w % 64'(PRIME));
    endfunction

    // Squarer model: one result every LAT cycles after launch, optional stall after N results.
    logic [MOD_LEN-1:0] m_cur    = '0;
    int                 m_cnt    = 0;
    logic               m_active = 1'b0;
    int                 m_nvalid = 0;
    int                 stall_after = 0;

    always @(posedge clk) begin
        if (sq_reset) begin
            m_active <= 1'b0;
            sq_valid <= 1'b0;
            m_cnt    <= 0;
        end else if (sq_start) begin
            m_active <= 1'b1;
            m_cur    <= sq_in;
            m_cnt    <= 0;
            m_nvalid <= 0;
            sq_valid <= 1'b0;
        end else if (m_active) begin
            if (m_cnt == LAT - 1) begin
                sq_out   <= sq_mod(m_cur);
                m_cur    <= sq_mod(m_cur);
                sq_valid <= 1'b1;
                m_cnt    <= 0;
                m_nvalid <= m_nvalid + 1;
                if (stall_after != 0 && m_nvalid + 1 >= stall_after) m_active <= 1'b0;
            end else begin
                m_cnt    <= m_cnt + 1;
                sq_valid <= 1'b0;
            end
        end else begin
            sq_valid <= 1'b0;
        end
    end

    int   start_pulses = 0;
    int   pre_run      = 0;
    int   last_pre     = 0;
    bit   sq_reset_low_seen = 1'b0;
    bit   rand_ready   = 1'b0;
    bit   hold_prev    = 1'b0;
    logic [MOD_LEN-1:0] hold_y;
    logic [CNT_W-1:0]   hold_iters;
    logic               hold_err;

    // Output monitor: launch bookkeeping, response stability and scoreboard pops.
    initial forever begin
        @(negedge clk);
        if (sq_start) begin
            start_pulses++;
            last_pre = pre_run;
            pre_run  = 0;
        end else if (busy && sq_reset) begin
            pre_run++;
        end else begin
            pre_run = 0;
        end
        if (!sq_reset) sq_reset_low_seen = 1'b1;
        if (hold_prev) begin
            check_eq("hold_valid", 64'(host_if.resp_valid), 64'(1));
            check_eq("hold_y", 64'(host_if.resp_y), 64'(hold_y));
            check_eq("hold_iters", 64'(host_if.resp_iters), 64'(hold_iters));
            check_eq("hold_err", 64'(host_if.resp_err), 64'(hold_err));
        end
        hold_prev  = host_if.resp_valid && !host_if.resp_ready && !reset;
        hold_y     = host_if.resp_y;
        hold_iters = host_if.resp_iters;
        hold_err   = host_if.resp_err;
        if (host_if.req_valid && host_if.req_ready) check_eq("accept_in_idle", 64'(busy), 64'(0));
        if (host_if.resp_valid && host_if.resp_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_extra_resp", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("resp_y", 64'(host_if.resp_y), e.y);
                check_eq("resp_iters", 64'(host_if.resp_iters), e.iters);
                check_eq("resp_err", 64'(host_if.resp_err), e.err);
            end
        end
    end

    // Random backpressure on the response channel when enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) host_if.resp_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic submit(input int x, input int t, input bit push, input int ey,
                          input int ei, input int ee, input bit keep);
        int n;
        exp_t e;
        if (push) begin
            e.y = 64'(ey); e.iters = 64'(ei); e.err = 64'(ee);
            sb_q.push_back(e);
        end
        host_if.req_x     = MOD_LEN'(x);
        host_if.req_t     = CNT_W'(t);
        host_if.req_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (host_if.req_ready) break;
            n++;
            if (n > 2000) begin
                check_eq("req_accept_timeout", 64'(n), 64'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) host_if.req_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) check_eq("drain_timeout", 64'(sb_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s0;
        int n;
        bit seen;
        int jx[3];
        int jt[3];
        int jy[3];
        host_if.req_valid  = 1'b0;
        host_if.req_x      = '0;
        host_if.req_t      = '0;
        host_if.resp_ready = 1'b0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", 64'(host_if.req_ready), 64'(0));
        check_eq("rst_resp_valid", 64'(host_if.resp_valid), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_sq_reset", 64'(sq_reset), 64'(1));
        check_eq("rst_sq_start", 64'(sq_start), 64'(0));
        check_eq("rst_sq_in", 64'(sq_in), 64'(0));
        check_eq("rst_resp_y", 64'(host_if.resp_y), 64'(0));
        check_eq("rst_resp_iters", 64'(host_if.resp_iters), 64'(0));
        check_eq("rst_resp_err", 64'(host_if.resp_err), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("ready_lag", 64'(host_if.req_ready), 64'(0));
        @(negedge clk);
        check_eq("ready_after_reset", 64'(host_if.req_ready), 64'(1));

        // x=5, T=2 -> 625 with one launch after 8 squarer-reset cycles.
        @(posedge clk);
        #1 host_if.resp_ready = 1'b1;
        s0 = start_pulses;
        submit(5, 2, 1'b1, 625, 2, 0, 1'b0);
        drain(500);
        check_eq("one_start", 64'(start_pulses - s0), 64'(1));
        check_eq("sqrst_cycles", 64'(last_pre), 64'(SQRST));
        @(negedge clk);
        check_eq("idle_sq_reset", 64'(sq_reset), 64'(1));
        check_eq("idle_ready", 64'(host_if.req_ready), 64'(1));

        // x=5, T=3 -> 142 under 50 cycles of backpressure.
        @(posedge clk);
        #1 host_if.resp_ready = 1'b0;
        submit(5, 3, 1'b1, 142, 3, 0, 1'b0);
        n = 0;
        while (!host_if.resp_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("t3_resp_seen", 64'(host_if.resp_valid), 64'(1));
        repeat (50) @(negedge clk);
        check_eq("t3_still_valid", 64'(host_if.resp_valid), 64'(1));
        @(posedge clk);
        #1 host_if.resp_ready = 1'b1;
        @(posedge clk);
        #1 host_if.resp_ready = 1'b0;
        @(negedge clk);
        check_eq("t3_valid_drop", 64'(host_if.resp_valid), 64'(0));
        check_eq("t3_ready_back", 64'(host_if.req_ready), 64'(1));
        check_eq("t3_sb_empty", 64'(sb_q.size()), 64'(0));

        // T=0 bypasses the squarer entirely.
        @(posedge clk);
        #1 host_if.resp_ready = 1'b1;
        s0 = start_pulses;
        sq_reset_low_seen = 1'b0;
        submit(77, 0, 1'b1, 77, 0, 0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (host_if.resp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("t0_latency", 64'(seen), 64'(1));
        drain(10);
        check_eq("t0_no_start", 64'(start_pulses - s0), 64'(0));
        check_eq("t0_sq_reset_held", 64'(sq_reset_low_seen), 64'(0));

        // Stall after the first result forces a timeout abort.
        stall_after = 1;
        submit(5, 4, 1'b1, 25, 1, 1, 1'b0);
        drain(1000);
        stall_after = 0;

        // Reset in RUN discards the job; a fresh job still completes.
        submit(5, 3, 1'b0, 0, 0, 0, 1'b0);
        n = 0;
        while (m_nvalid < 1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_first_valid", 64'(m_nvalid), 64'(1));
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_eq("mid_sq_reset_now", 64'(sq_reset), 64'(1));
        @(negedge clk);
        check_eq("mid_busy", 64'(busy), 64'(0));
        check_eq("mid_sq_reset", 64'(sq_reset), 64'(1));
        check_eq("mid_resp_valid", 64'(host_if.resp_valid), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("mid_no_resp", 64'(host_if.resp_valid), 64'(0));
        @(posedge clk);
        #1;
        submit(5, 2, 1'b1, 625, 2, 0, 1'b0);
        drain(500);

        // Back-to-back jobs with req_valid held and random response backpressure.
        jx = '{7, 3, 2};
        jt = '{2, 0, 3};
        jy = '{383, 3, 256};
        rand_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            submit(jx[i], jt[i], 1'b1, jy[i], jt[i], 0, 1'b1);
        end
        host_if.req_valid = 1'b0;
        drain(3000);
        rand_ready = 1'b0;
        @(posedge clk);
        #1 host_if.resp_ready = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("final_sb_empty", 64'(sb_q.size()), 64'(0));
        check_eq("final_idle", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
